// File: rtl/maxpool2x2_stream_pkg.sv
// Shared constants and helpers for the streaming 2x2/stride-2 pooling stage.
// Defaults match the block-3 pool (56x56x16, 32-bit samples).
package maxpool2x2_stream_pkg;

  localparam int POOL_MAX     = 0;
  localparam int POOL_AVG     = 1;
  localparam int SAMPLE_WIDTH = 32;
  localparam int B3_WIDTH     = 56;
  localparam int B3_CHANNELS  = 16;

  // Bits needed for a counter running 0..n-1; never zero so tiny frames still elaborate.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Pixel stream bundle between the producer and the pooling stage.
// Both directions live here because there is no backpressure path.
interface maxpool2x2_stream_if
  import maxpool2x2_stream_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_WIDTH,
  parameter int CHANNELS   = B3_CHANNELS
);
  logic [DATA_WIDTH*CHANNELS-1:0] i_data;
  logic                           valid_in;
  logic [DATA_WIDTH*CHANNELS-1:0] o_data;
  logic                           valid_out;
  logic                           frame_done;

  modport master (output i_data, valid_in, input o_data, valid_out, frame_done);
  modport slave  (input i_data, valid_in, output o_data, valid_out, frame_done);
endinterface

// File: rtl/maxpool2x2_stream_line_buffer.sv
// Half-row buffer holding the horizontal pair results of each even row.
// Contents are never reset: every entry is rewritten before the odd row reads it.
module maxpool2x2_stream_line_buffer
  import maxpool2x2_stream_pkg::*;
#(
  parameter int DEPTH   = 28,
  parameter int ENTRY_W = 512,
  parameter int ADDR_W  = cnt_width(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2/stride-2 max or average pool over a raster of packed multi-channel pixels.
// One output per 2x2 block, registered one cycle after its bottom-right pixel.
module maxpool2x2_stream
  import maxpool2x2_stream_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_WIDTH,
  parameter int CHANNELS   = B3_CHANNELS,
  parameter int WIDTH      = B3_WIDTH,
  parameter int HEIGHT     = B3_WIDTH,
  parameter int POOL_MODE  = POOL_MAX
) (
  input logic               clk,
  input logic               rst,
  maxpool2x2_stream_if.slave bus
);

  localparam int DW    = DATA_WIDTH;
  localparam int BUS_W = DW * CHANNELS;
  localparam int LB_W  = (POOL_MODE == POOL_AVG) ? DW + 1 : DW;
  localparam int CW    = cnt_width(WIDTH);
  localparam int RW    = cnt_width(HEIGHT);
  localparam int DEPTH = WIDTH / 2;
  localparam int AW    = cnt_width(DEPTH);

  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  logic [BUS_W-1:0]         hold;
  logic [BUS_W-1:0]         res;
  logic [CHANNELS*LB_W-1:0] lb_wr;
  logic [CHANNELS*LB_W-1:0] lb_rd;
  logic [AW-1:0]            lb_addr;
  logic                     col_last;
  logic                     row_last;
  logic                     lb_we;
  logic                     emit;

  assign col_last = (col == CW'(WIDTH - 1));
  assign row_last = (row == RW'(HEIGHT - 1));
  assign lb_we    = bus.valid_in & ~row[0] & col[0];
  assign emit     = bus.valid_in & row[0] & col[0];
  assign lb_addr  = AW'(col >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (bus.valid_in) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold <= '0;
    else if (bus.valid_in && !col[0]) hold <= bus.i_data;
  end

  maxpool2x2_stream_line_buffer #(
    .DEPTH  (DEPTH),
    .ENTRY_W(CHANNELS * LB_W),
    .ADDR_W (AW)
  ) u_line_buffer (
    .clk    (clk),
    .we     (lb_we),
    .wr_addr(lb_addr),
    .wr_data(lb_wr),
    .rd_addr(lb_addr),
    .rd_data(lb_rd)
  );

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [DW-1:0] px;
    logic signed [DW-1:0] hd;
    logic [LB_W-1:0]      lb;

    assign px = bus.i_data[c*DW +: DW];
    assign hd = hold[c*DW +: DW];
    assign lb = lb_rd[c*LB_W +: LB_W];

    if (POOL_MODE == POOL_AVG) begin : g_avg
      logic [DW+1:0] sum;
      assign lb_wr[c*LB_W +: LB_W] = {hd[DW-1], hd} + {px[DW-1], px};
      assign sum = {lb[LB_W-1], lb} + {{2{hd[DW-1]}}, hd} + {{2{px[DW-1]}}, px};
      // Floor divide by four; the quotient of four DW-bit values always fits in DW.
      assign res[c*DW +: DW] = sum[DW+1:2];
    end else begin : g_max
      logic signed [DW-1:0] lbs;
      logic signed [DW-1:0] m1;
      assign lb_wr[c*LB_W +: LB_W] = (px > hd) ? px : hd;
      assign lbs = lb;
      assign m1  = (lbs > hd) ? lbs : hd;
      assign res[c*DW +: DW] = (px > m1) ? px : m1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.o_data     <= '0;
      bus.valid_out  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.valid_out  <= emit;
      bus.frame_done <= emit & row_last & col_last;
      if (emit) bus.o_data <= res;
    end
  end

endmodule
